// File: rtl/otter_sa_dcache.sv
// N-way set-associative write-back, write-allocate data cache for the OTTER RV32I core.
// Lookup is combinational in IDLE; misses write back a dirty victim, then refill word by word.
module otter_sa_dcache #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned SETS       = 4,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CPU_RD,
    input  logic        CPU_WE,
    input  logic [31:0] CPU_ADDR,
    input  logic [31:0] CPU_DIN,
    input  logic [1:0]  CPU_SIZE,
    input  logic        CPU_SIGN,
    output logic [31:0] CPU_DOUT,
    output logic        STALL,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);
    localparam int unsigned WORD_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = 30 - WORD_W - IDX_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

    state_t              state;
    logic [WORD_W-1:0]   cnt_q;
    logic [WAY_W-1:0]    victim_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    req_tag_q;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WAYS-1:0]     dirty_q [SETS];
    logic [WAY_W-1:0]    ptr_q   [SETS];
    logic [TAG_W-1:0]    tag_q   [WAYS][SETS];
    logic [31:0]         data_q  [WAYS][SETS][LINE_WORDS];

    logic [1:0]          a_off;
    logic [WORD_W-1:0]   a_word;
    logic [IDX_W-1:0]    a_idx;
    logic [TAG_W-1:0]    a_tag;

    assign a_off  = CPU_ADDR[1:0];
    assign a_word = CPU_ADDR[WORD_W+1:2];
    assign a_idx  = CPU_ADDR[WORD_W+IDX_W+1:WORD_W+2];
    assign a_tag  = CPU_ADDR[31:WORD_W+IDX_W+2];

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              inv_found;
    logic [WAY_W-1:0]  inv_way;
    logic [WAY_W-1:0]  victim;
    logic              legal;
    logic              req;
    logic              store_hit;
    logic              refill_last;
    logic [WORD_W-1:0] cnt_nxt;
    logic [WORD_W-1:0] cnt_last;
    logic [31:0]       rd_word;
    logic [31:0]       shifted;
    logic [31:0]       wdata_sh;
    logic [3:0]        be;
    logic [31:0]       merged;

    assign cnt_nxt  = cnt_q + 1'b1;
    assign cnt_last = WORD_W'(LINE_WORDS - 1);

    // Tag compare and first-invalid-way search over the indexed set
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[a_idx][w] && (tag_q[w][a_idx] == a_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[a_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : ptr_q[a_idx];
    end

    // Size/offset legality and byte-lane enables
    always_comb begin
        legal = 1'b0;
        be    = 4'b0000;
        case (CPU_SIZE)
            2'd0: begin legal = 1'b1;             be = 4'b0001 << a_off; end
            2'd1: begin legal = (a_off != 2'd3);  be = 4'b0011 << a_off; end
            2'd2: begin legal = (a_off == 2'd0);  be = 4'b1111;          end
            default: begin legal = 1'b0;          be = 4'b0000;          end
        endcase
    end

    assign req         = (CPU_RD | CPU_WE) & legal;
    assign store_hit   = (state == IDLE) && req && hit && CPU_WE;
    assign refill_last = (state == REFILL) && MEM_ACK && (cnt_q == cnt_last);
    assign STALL       = (state != IDLE) || (req && !hit);

    assign rd_word  = data_q[hit_way][a_idx][a_word];
    assign shifted  = rd_word >> {a_off, 3'b000};
    assign wdata_sh = CPU_DIN << {a_off, 3'b000};

    always_comb begin
        merged = rd_word;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) merged[i*8 +: 8] = wdata_sh[i*8 +: 8];
        end
    end

    // Load data sizing and extension; zero whenever nothing is being serviced
    always_comb begin
        CPU_DOUT = '0;
        if ((state == IDLE) && CPU_RD && !CPU_WE && legal && hit) begin
            case (CPU_SIZE)
                2'd0:    CPU_DOUT = {{24{~CPU_SIGN & shifted[7]}},  shifted[7:0]};
                2'd1:    CPU_DOUT = {{16{~CPU_SIGN & shifted[15]}}, shifted[15:0]};
                default: CPU_DOUT = shifted;
            endcase
        end
    end

    // Line data and tags carry no reset; only valid bits define contents
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (store_hit) data_q[hit_way][a_idx][a_word] <= merged;
            if ((state == REFILL) && MEM_ACK) data_q[victim_q][idx_q][cnt_q] <= MEM_RDATA;
            if (refill_last) tag_q[victim_q][idx_q] <= req_tag_q;
        end
    end

    // Controller: miss handling, line state and registered memory-side outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt_q     <= '0;
            victim_q  <= '0;
            idx_q     <= '0;
            req_tag_q <= '0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (store_hit) dirty_q[a_idx][hit_way] <= 1'b1;
                    if (req && !hit) begin
                        victim_q  <= victim;
                        idx_q     <= a_idx;
                        req_tag_q <= a_tag;
                        cnt_q     <= '0;
                        MEM_REQ   <= 1'b1;
                        if (!inv_found) begin
                            ptr_q[a_idx] <= (ptr_q[a_idx] == WAY_W'(WAYS - 1)) ? '0
                                                                                : ptr_q[a_idx] + 1'b1;
                        end
                        if (dirty_q[a_idx][victim]) begin
                            state     <= WB;
                            MEM_WE    <= 1'b1;
                            MEM_ADDR  <= {tag_q[victim][a_idx], a_idx, {WORD_W{1'b0}}, 2'b00};
                            MEM_WDATA <= data_q[victim][a_idx][0];
                        end else begin
                            state    <= REFILL;
                            MEM_WE   <= 1'b0;
                            MEM_ADDR <= {a_tag, a_idx, {WORD_W{1'b0}}, 2'b00};
                        end
                    end
                end
                WB: begin
                    if (MEM_ACK) begin
                        if (cnt_q == cnt_last) begin
                            dirty_q[idx_q][victim_q] <= 1'b0;
                            state    <= REFILL;
                            cnt_q    <= '0;
                            MEM_WE   <= 1'b0;
                            MEM_ADDR <= {req_tag_q, idx_q, {WORD_W{1'b0}}, 2'b00};
                        end else begin
                            cnt_q     <= cnt_nxt;
                            MEM_ADDR  <= {tag_q[victim_q][idx_q], idx_q, cnt_nxt, 2'b00};
                            MEM_WDATA <= data_q[victim_q][idx_q][cnt_nxt];
                        end
                    end
                end
                REFILL: begin
                    if (MEM_ACK) begin
                        if (cnt_q == cnt_last) begin
                            valid_q[idx_q][victim_q] <= 1'b1;
                            dirty_q[idx_q][victim_q] <= 1'b0;
                            state   <= IDLE;
                            cnt_q   <= '0;
                            MEM_REQ <= 1'b0;
                            MEM_WE  <= 1'b0;
                        end else begin
                            cnt_q    <= cnt_nxt;
                            MEM_ADDR <= {req_tag_q, idx_q, cnt_nxt, 2'b00};
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    MEM_REQ <= 1'b0;
                    MEM_WE  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_otter_sa_dcache.sv
// Directed bench for otter_sa_dcache (2 ways, 4 sets, 4-word lines) with a word-serial memory model.
module tb_otter_sa_dcache;
    logic        CLK = 1'b0;
    logic        RST;
    logic        CPU_RD, CPU_WE, CPU_SIGN;
    logic [31:0] CPU_ADDR, CPU_DIN, CPU_DOUT;
    logic [1:0]  CPU_SIZE;
    logic        STALL, MEM_REQ, MEM_WE, MEM_ACK;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

    otter_sa_dcache #(.WAYS(2), .SETS(4), .LINE_WORDS(4)) dut (
        .CLK(CLK), .RST(RST),
        .CPU_RD(CPU_RD), .CPU_WE(CPU_WE), .CPU_ADDR(CPU_ADDR), .CPU_DIN(CPU_DIN),
        .CPU_SIZE(CPU_SIZE), .CPU_SIGN(CPU_SIGN), .CPU_DOUT(CPU_DOUT), .STALL(STALL),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    logic [31:0] mem [int unsigned];
    logic [31:0] log_addr [$];
    logic        log_we [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Untouched words read back as CAFE in the top half and the address in the bottom half
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hCAFE_0000 | {16'h0000, a[15:0]};
    endfunction

    // Backing memory: acks each word after ack_delay waiting cycles
    initial begin
        int wait_cnt;
        logic [31:0] hold;
        wait_cnt  = 0;
        hold      = '0;
        MEM_ACK   = 1'b0;
        MEM_RDATA = '0;
        forever begin
            @(negedge CLK);
            MEM_ACK = 1'b0;
            if (RST || !MEM_REQ) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) hold = MEM_ADDR;
                if (wait_cnt < ack_delay) begin
                    wait_cnt++;
                end else begin
                    if (ack_delay > 0) check("addr_stable", MEM_ADDR, hold);
                    MEM_ACK  = 1'b1;
                    wait_cnt = 0;
                    log_addr.push_back(MEM_ADDR);
                    log_we.push_back(MEM_WE);
                    if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
                    else        MEM_RDATA = mem_rd(MEM_ADDR);
                end
            end
        end
    end

    task automatic access(input logic rd, input logic we, input logic [31:0] addr,
                          input logic [31:0] din, input logic [1:0] size, input logic sign,
                          output logic [31:0] dout, output int cycles, output logic first_stall);
        @(negedge CLK);
        CPU_RD = rd; CPU_WE = we; CPU_ADDR = addr; CPU_DIN = din; CPU_SIZE = size; CPU_SIGN = sign;
        #1;
        first_stall = STALL;
        cycles = 0;
        while (STALL === 1'b1 && cycles < 200) begin
            @(negedge CLK);
            #1;
            cycles++;
        end
        dout = CPU_DOUT;
        check("stall_release", {31'b0, STALL}, 32'd0);
        @(posedge CLK);
        #1;
        CPU_RD = 1'b0; CPU_WE = 1'b0;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                        input logic sign, input logic [31:0] exp, input int exp_cycles);
        logic [31:0] d; int c; logic fs;
        access(1'b1, 1'b0, addr, 32'h0, size, sign, d, c, fs);
        check({tag, "_dout"}, d, exp);
        check({tag, "_cycles"}, 32'(c), 32'(exp_cycles));
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] din,
                         input logic [1:0] size);
        logic [31:0] d; int c; logic fs;
        access(1'b0, 1'b1, addr, din, size, 1'b0, d, c, fs);
        check({tag, "_stall"}, {31'b0, fs}, 32'd0);
    endtask

    task automatic check_log(input string tag, input logic [31:0] base, input logic we, input int n);
        check({tag, "_count"}, 32'(log_addr.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i),
                  (i < log_addr.size()) ? log_addr[i] : 32'hFFFF_FFFF, base + 32'(4 * i));
            check($sformatf("%s_we%0d", tag, i),
                  (i < log_we.size()) ? {31'b0, log_we[i]} : 32'hFFFF_FFFF, {31'b0, we});
        end
    endtask

    initial begin
        logic [31:0] d; int c; logic fs;
        RST = 1'b1; CPU_RD = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
        CPU_SIZE = 2'd2; CPU_SIGN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall",   {31'b0, STALL},   32'd0);
        check("rst_mem_req", {31'b0, MEM_REQ}, 32'd0);
        check("rst_mem_we",  {31'b0, MEM_WE},  32'd0);
        check("rst_dout",    CPU_DOUT,         32'd0);
        RST = 1'b0;

        // Cold miss refills four words, then hits
        log_addr.delete(); log_we.delete();
        access(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b0, d, c, fs);
        check("t1_first_stall", {31'b0, fs}, 32'd1);
        check("t1_dout", d, 32'hCAFE_0100);
        check("t1_cycles", 32'(c), 32'd5);
        check_log("t1_log", 32'h100, 1'b0, 4);
        log_addr.delete(); log_we.delete();
        load("t1_hit", 32'h10C, 2'd2, 1'b0, 32'hCAFE_010C, 0);
        @(negedge CLK);
        check("idle_dout", CPU_DOUT, 32'd0);

        // Byte/half/word stores and sized loads on the resident line
        store("t2_sb", 32'h101, 32'h0000_00AB, 2'd0);
        load("t2_lbu", 32'h101, 2'd0, 1'b1, 32'h0000_00AB, 0);
        load("t2_lb",  32'h101, 2'd0, 1'b0, 32'hFFFF_FFAB, 0);
        load("t2_lw",  32'h100, 2'd2, 1'b0, 32'hCAFE_AB00, 0);
        load("t2_lh2", 32'h102, 2'd1, 1'b0, 32'hFFFF_CAFE, 0);
        load("t2_lhu", 32'h102, 2'd1, 1'b1, 32'h0000_CAFE, 0);
        load("t2_lh1", 32'h101, 2'd1, 1'b0, 32'hFFFF_FEAB, 0);
        load("t2_lb3", 32'h103, 2'd0, 1'b0, 32'hFFFF_FFCA, 0);
        store("t2_sw", 32'h104, 32'h1234_5678, 2'd2);
        load("t2_lw4", 32'h104, 2'd2, 1'b0, 32'h1234_5678, 0);

        // Fill the other way, then evict the dirty line
        log_addr.delete(); log_we.delete();
        load("t3_fill", 32'h140, 2'd2, 1'b0, 32'hCAFE_0140, 5);
        log_addr.delete(); log_we.delete();
        load("t3_evict", 32'h180, 2'd2, 1'b0, 32'hCAFE_0180, 9);
        check("t3_wb_count", 32'(log_addr.size()), 32'd8);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_wb_addr%0d", i), log_addr[i], 32'h100 + 32'(4 * i));
            check($sformatf("t3_wb_we%0d", i), {31'b0, log_we[i]}, 32'd1);
            check($sformatf("t3_rf_addr%0d", i), log_addr[i + 4], 32'h180 + 32'(4 * i));
            check($sformatf("t3_rf_we%0d", i), {31'b0, log_we[i + 4]}, 32'd0);
        end
        check("t3_mem100", mem_rd(32'h100), 32'hCAFE_AB00);
        check("t3_mem104", mem_rd(32'h104), 32'h1234_5678);
        check("t3_mem108", mem_rd(32'h108), 32'hCAFE_0108);
        check("t3_mem10c", mem_rd(32'h10C), 32'hCAFE_010C);
        load("t3_keep", 32'h140, 2'd2, 1'b0, 32'hCAFE_0140, 0);

        // Slow memory: 3 wait cycles per word, clean victim (way 1 by round robin)
        ack_delay = 3;
        log_addr.delete(); log_we.delete();
        load("t4_slow", 32'h100, 2'd2, 1'b0, 32'hCAFE_AB00, 17);
        check_log("t4_log", 32'h100, 1'b0, 4);

        // Reset in the middle of a refill
        @(negedge CLK);
        CPU_RD = 1'b1; CPU_WE = 1'b0; CPU_ADDR = 32'h1C0; CPU_SIZE = 2'd2; CPU_SIGN = 1'b0;
        repeat (6) @(negedge CLK);
        check("t5_mid_req", {31'b0, MEM_REQ}, 32'd1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("t5_req_drop", {31'b0, MEM_REQ}, 32'd0);
        RST = 1'b0; CPU_RD = 1'b0;
        @(negedge CLK);
        check("t5_stall", {31'b0, STALL}, 32'd0);
        ack_delay = 0;
        log_addr.delete(); log_we.delete();
        load("t5_relw", 32'h100, 2'd2, 1'b0, 32'hCAFE_AB00, 5);
        check_log("t5_log", 32'h100, 1'b0, 4);

        // Misaligned accesses are ignored and leave the line clean
        access(1'b1, 1'b0, 32'h102, 32'h0, 2'd2, 1'b0, d, c, fs);
        check("t6_lw_dout", d, 32'd0);
        check("t6_lw_stall", {31'b0, fs}, 32'd0);
        store("t6_sh", 32'h103, 32'h0000_BEEF, 2'd1);
        load("t6_unchanged", 32'h100, 2'd2, 1'b0, 32'hCAFE_AB00, 0);
        load("t6_fill", 32'h140, 2'd2, 1'b0, 32'hCAFE_0140, 5);
        log_addr.delete(); log_we.delete();
        load("t6_clean_evict", 32'h180, 2'd2, 1'b0, 32'hCAFE_0180, 5);
        check_log("t6_log", 32'h180, 1'b0, 4);

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
